// File: rtl/i2c_regs_pkg.sv
// Register map of the I2C controller's Wishbone slave port and the sequencer state encoding.
package i2c_regs_pkg;

    localparam logic [7:0] I2C_START           = 8'h00;
    localparam logic [7:0] I2C_WRITE           = 8'h04;
    localparam logic [7:0] I2C_STOP            = 8'h08;
    localparam logic [7:0] I2C_ACK             = 8'h0C;
    localparam logic [7:0] I2C_READ_DATA_READY = 8'h10;
    localparam logic [7:0] I2C_BUSY            = 8'h14;
    localparam logic [7:0] I2C_READ            = 8'h18;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WR_START  = 4'd1,
        ST_WR_DATA   = 4'd2,
        ST_POLL_BUSY = 4'd3,
        ST_RD_ACK    = 4'd4,
        ST_POLL_RDY  = 4'd5,
        ST_RD_DATA   = 4'd6,
        ST_WR_STOP   = 4'd7,
        ST_RESP      = 4'd8
    } seq_state_e;

endpackage

// File: rtl/i2c_wb_sequencer_if.sv
// Wishbone initiator-side bundle between the sequencer and the I2C controller register port.
interface i2c_wb_sequencer_if #(
    parameter int AW = 8,
    parameter int DW = 32
) ();
    logic          o_wb_cyc;
    logic          o_wb_stb;
    logic          o_wb_we;
    logic [AW-1:0] o_wb_addr;
    logic [DW-1:0] o_wb_data;
    logic [DW-1:0] i_wb_data;
    logic          i_wb_ack;

    modport master (
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
        input  i_wb_data, i_wb_ack
    );

    modport slave (
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
        output i_wb_data, i_wb_ack
    );
endinterface

// File: rtl/wb_single_access.sv
// One Wishbone classic access: holds cyc/stb until the first ack, then one idle cycle.
module wb_single_access #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [DW-1:0] wdata,
    output logic          done,
    output logic [7:0]    rdata,
    i2c_wb_sequencer_if.master wb
);
    localparam logic [1:0] AS_IDLE   = 2'd0;
    localparam logic [1:0] AS_ACTIVE = 2'd1;
    localparam logic [1:0] AS_GAP    = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          unused_rdata_hi;

    // The gap cycle may accept the next request so accesses are spaced by exactly one idle cycle;
    // the slave's trailing ack in that cycle is ignored because only ACTIVE looks at ack.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        case (state_q)
            AS_ACTIVE: begin
                if (wb.i_wb_ack) state_d = AS_GAP;
            end
            default: begin
                if (req) begin
                    state_d = AS_ACTIVE;
                    addr_d  = addr;
                    we_d    = we;
                    wdata_d = wdata;
                end else begin
                    state_d = AS_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= AS_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    assign wb.o_wb_cyc  = (state_q == AS_ACTIVE);
    assign wb.o_wb_stb  = (state_q == AS_ACTIVE);
    assign wb.o_wb_we   = we_q;
    assign wb.o_wb_addr = addr_q;
    assign wb.o_wb_data = wdata_q;

    assign done            = (state_q == AS_ACTIVE) && wb.i_wb_ack;
    assign rdata           = wb.i_wb_data[7:0];
    assign unused_rdata_hi = ^wb.i_wb_data[DW-1:8];
endmodule

// File: rtl/i2c_wb_sequencer.sv
// Turns one I2C byte command into the controller's register access sequence and returns one response.
module i2c_wb_sequencer
    import i2c_regs_pkg::*;
#(
    parameter int AW           = 8,
    parameter int DW           = 32,
    parameter int POLL_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_slave_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       rsp_timeout,
    i2c_wb_sequencer_if.master wb
);
    localparam int CW = $clog2(POLL_TIMEOUT + 1);

    seq_state_e    state_q, state_d;
    logic          rw_q, rw_d;
    logic [6:0]    saddr_q, saddr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [CW-1:0] poll_cnt_q, poll_cnt_d;
    logic          nack_q, nack_d;
    logic          timeout_q, timeout_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          poll_last;

    logic          acc_req, acc_we, acc_done;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;
    logic [7:0]    acc_rdata;

    assign poll_last = (poll_cnt_q == CW'(POLL_TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        saddr_d    = saddr_q;
        wdata_d    = wdata_q;
        poll_cnt_d = poll_cnt_q;
        nack_d     = nack_q;
        timeout_d  = timeout_q;
        rdata_d    = rdata_q;
        case (state_q)
            ST_IDLE: begin
                nack_d    = 1'b0;
                timeout_d = 1'b0;
                rdata_d   = 8'd0;
                if (cmd_valid) begin
                    rw_d    = cmd_rw;
                    saddr_d = cmd_slave_addr;
                    wdata_d = cmd_wdata;
                    state_d = ST_WR_START;
                end
            end
            ST_WR_START: begin
                if (acc_done) begin
                    poll_cnt_d = '0;
                    state_d    = rw_q ? ST_POLL_BUSY : ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (acc_done) begin
                    poll_cnt_d = '0;
                    state_d    = ST_POLL_BUSY;
                end
            end
            ST_POLL_BUSY: begin
                if (acc_done) begin
                    if (!acc_rdata[0]) begin
                        state_d = ST_RD_ACK;
                    end else if (poll_last) begin
                        timeout_d = 1'b1;
                        state_d   = ST_WR_STOP;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 1'b1;
                    end
                end
            end
            ST_RD_ACK: begin
                if (acc_done) begin
                    if (!acc_rdata[0]) begin
                        nack_d  = 1'b1;
                        state_d = ST_WR_STOP;
                    end else if (rw_q) begin
                        poll_cnt_d = '0;
                        state_d    = ST_POLL_RDY;
                    end else begin
                        state_d = ST_WR_STOP;
                    end
                end
            end
            ST_POLL_RDY: begin
                if (acc_done) begin
                    if (acc_rdata[0]) begin
                        state_d = ST_RD_DATA;
                    end else if (poll_last) begin
                        timeout_d = 1'b1;
                        state_d   = ST_WR_STOP;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 1'b1;
                    end
                end
            end
            ST_RD_DATA: begin
                if (acc_done) begin
                    rdata_d = acc_rdata;
                    state_d = ST_WR_STOP;
                end
            end
            ST_WR_STOP: begin
                if (acc_done) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Requests follow the next state so the first access starts right after the handshake
    // and each follow-up access can be taken in the access unit's idle cycle.
    always_comb begin
        acc_req   = 1'b1;
        acc_we    = 1'b0;
        acc_addr  = AW'(I2C_BUSY);
        acc_wdata = '0;
        case (state_d)
            ST_WR_START: begin
                acc_we    = 1'b1;
                acc_addr  = AW'(I2C_START);
                acc_wdata = DW'({saddr_d, rw_d});
            end
            ST_WR_DATA: begin
                acc_we    = 1'b1;
                acc_addr  = AW'(I2C_WRITE);
                acc_wdata = DW'(wdata_d);
            end
            ST_POLL_BUSY: acc_addr = AW'(I2C_BUSY);
            ST_RD_ACK:    acc_addr = AW'(I2C_ACK);
            ST_POLL_RDY:  acc_addr = AW'(I2C_READ_DATA_READY);
            ST_RD_DATA:   acc_addr = AW'(I2C_READ);
            ST_WR_STOP: begin
                acc_we    = 1'b1;
                acc_addr  = AW'(I2C_STOP);
                acc_wdata = DW'(1'b1);
            end
            default: acc_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rw_q       <= 1'b0;
            saddr_q    <= '0;
            wdata_q    <= '0;
            poll_cnt_q <= '0;
            nack_q     <= 1'b0;
            timeout_q  <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            saddr_q    <= saddr_d;
            wdata_q    <= wdata_d;
            poll_cnt_q <= poll_cnt_d;
            nack_q     <= nack_d;
            timeout_q  <= timeout_d;
            rdata_q    <= rdata_d;
        end
    end

    wb_single_access #(
        .AW(AW),
        .DW(DW)
    ) u_access (
        .clk  (clk),
        .rst  (rst),
        .req  (acc_req),
        .addr (acc_addr),
        .we   (acc_we),
        .wdata(acc_wdata),
        .done (acc_done),
        .rdata(acc_rdata),
        .wb   (wb)
    );

    assign cmd_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_nack    = nack_q;
    assign rsp_timeout = timeout_q;
endmodule

// File: tb/tb_i2c_wb_sequencer.sv
// Randomized scoreboard bench: a register-port slave model plus a transaction-level reference of the access list.
module tb_i2c_wb_sequencer;
    import i2c_regs_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int T  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_slave_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;
    logic       rsp_timeout;

    always #5 clk = ~clk;

    i2c_wb_sequencer_if #(.AW(AW), .DW(DW)) wb_bus ();

    i2c_wb_sequencer #(.AW(AW), .DW(DW), .POLL_TIMEOUT(T)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_rw        (cmd_rw),
        .cmd_slave_addr(cmd_slave_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_nack      (rsp_nack),
        .rsp_timeout   (rsp_timeout),
        .wb            (wb_bus)
    );

    // Slave model: ack is registered cyc&stb; status registers answer from per-command settings.
    int          cfg_busy_n = 0;
    int          cfg_rdy_n  = 0;
    logic        cfg_ack    = 1'b1;
    logic [7:0]  cfg_rbyte  = 8'h00;
    int          busy_cnt   = 0;
    int          rdy_cnt    = 0;
    logic        sl_ack     = 1'b0;
    logic [31:0] sl_data;

    assign wb_bus.i_wb_ack  = sl_ack;
    assign wb_bus.i_wb_data = sl_data;

    always @(posedge clk) begin
        sl_ack <= wb_bus.o_wb_cyc & wb_bus.o_wb_stb;
        if (!rst && wb_bus.o_wb_cyc && wb_bus.o_wb_stb && sl_ack) begin
            if (wb_bus.o_wb_we && wb_bus.o_wb_addr == I2C_START) begin
                busy_cnt <= 0;
                rdy_cnt  <= 0;
            end else if (!wb_bus.o_wb_we && wb_bus.o_wb_addr == I2C_BUSY) begin
                busy_cnt <= busy_cnt + 1;
            end else if (!wb_bus.o_wb_we && wb_bus.o_wb_addr == I2C_READ_DATA_READY) begin
                rdy_cnt <= rdy_cnt + 1;
            end
        end
    end

    always_comb begin
        sl_data = 32'hDEAD_BEEF;
        case (wb_bus.o_wb_addr)
            I2C_BUSY:            sl_data = 32'hFFFF_FFFE | {31'd0, (busy_cnt < cfg_busy_n)};
            I2C_ACK:             sl_data = 32'hFFFF_FFFE | {31'd0, cfg_ack};
            I2C_READ_DATA_READY: sl_data = 32'hFFFF_FFFE | {31'd0, (rdy_cnt >= cfg_rdy_n)};
            I2C_READ:            sl_data = {24'h5A5A5A, cfg_rbyte};
            default:             sl_data = 32'hDEAD_BEEF;
        endcase
    end

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
    } acc_t;

    typedef struct {
        logic [7:0] rdata;
        logic       nack;
        logic       timeout;
        int         lat;
        int         issue;
    } rsp_t;

    acc_t exp_acc[$];
    rsp_t exp_rsp[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   cyc_n  = 0;
    int   n_rsp  = 0;
    acc_t mon_a;
    rsp_t mon_r;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc_n);
        end
    endtask

    function automatic acc_t mk(input logic we, input logic [7:0] addr, input logic [31:0] data);
        acc_t a;
        a.we   = we;
        a.addr = addr;
        a.data = data;
        return a;
    endfunction

    // Reference: the expected register accesses and response of one command, from the protocol rules.
    task automatic model(input logic rw, input logic [6:0] sa, input logic [7:0] wd, input int issue);
        rsp_t r;
        int   n = 0;
        r.rdata = 8'd0; r.nack = 1'b0; r.timeout = 1'b0;
        exp_acc.push_back(mk(1'b1, I2C_START, {24'd0, sa, rw})); n++;
        if (!rw) begin exp_acc.push_back(mk(1'b1, I2C_WRITE, {24'd0, wd})); n++; end
        if (cfg_busy_n >= T) begin
            for (int i = 0; i < T; i++) begin exp_acc.push_back(mk(1'b0, I2C_BUSY, 0)); n++; end
            r.timeout = 1'b1;
        end else begin
            for (int i = 0; i <= cfg_busy_n; i++) begin exp_acc.push_back(mk(1'b0, I2C_BUSY, 0)); n++; end
            exp_acc.push_back(mk(1'b0, I2C_ACK, 0)); n++;
            if (!cfg_ack) begin
                r.nack = 1'b1;
            end else if (rw) begin
                if (cfg_rdy_n >= T) begin
                    for (int i = 0; i < T; i++) begin exp_acc.push_back(mk(1'b0, I2C_READ_DATA_READY, 0)); n++; end
                    r.timeout = 1'b1;
                end else begin
                    for (int i = 0; i <= cfg_rdy_n; i++) begin exp_acc.push_back(mk(1'b0, I2C_READ_DATA_READY, 0)); n++; end
                    exp_acc.push_back(mk(1'b0, I2C_READ, 0)); n++;
                    r.rdata = cfg_rbyte;
                end
            end
        end
        exp_acc.push_back(mk(1'b1, I2C_STOP, 32'd1)); n++;
        r.lat   = 3 * n;
        r.issue = issue;
        exp_rsp.push_back(r);
    endtask

    // Bus monitor: one expected access per first-ack cycle; the trailing ack with cyc=0 is not an access.
    always @(negedge clk) begin
        if (!rst && wb_bus.o_wb_cyc === 1'b1 && wb_bus.o_wb_stb === 1'b1 && sl_ack === 1'b1) begin
            if (exp_acc.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL acc_unexpected: got access addr=0x%0h we=%0d, required none",
                         wb_bus.o_wb_addr, wb_bus.o_wb_we);
            end else begin
                mon_a = exp_acc.pop_front();
                check("acc_we", {31'd0, wb_bus.o_wb_we}, {31'd0, mon_a.we});
                check("acc_addr", {24'd0, wb_bus.o_wb_addr}, {24'd0, mon_a.addr});
                if (mon_a.we) check("acc_wdata", wb_bus.o_wb_data, mon_a.data);
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (!rst && rsp_valid === 1'b1) begin
            if (exp_rsp.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rsp_unexpected: got rsp_valid=1, required no response");
            end else begin
                mon_r = exp_rsp.pop_front();
                n_rsp++;
                $display("rsp %0d: rdata=0x%02h nack=%0d timeout=%0d latency=%0d", n_rsp,
                         rsp_rdata, rsp_nack, rsp_timeout, cyc_n - mon_r.issue);
                check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, mon_r.rdata});
                check("rsp_nack", {31'd0, rsp_nack}, {31'd0, mon_r.nack});
                check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, mon_r.timeout});
                check("rsp_latency", cyc_n - mon_r.issue, mon_r.lat);
                check("acc_left", exp_acc.size(), 0);
            end
        end
    end

    task automatic issue_cmd(input logic rw, input logic [6:0] sa, input logic [7:0] wd,
                             input int busy_n, input logic ack, input int rdy_n, input logic [7:0] rb);
        int w = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && w < 400) begin @(negedge clk); w++; end
        check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        if (cmd_ready !== 1'b1) return;
        cfg_busy_n = busy_n; cfg_ack = ack; cfg_rdy_n = rdy_n; cfg_rbyte = rb;
        cmd_rw = rw; cmd_slave_addr = sa; cmd_wdata = wd; cmd_valid = 1'b1;
        model(rw, sa, wd, cyc_n);
        @(negedge clk);
        cmd_valid = 1'b0;
        // Junk offers while busy must be ignored.
        for (int i = 0; i < 3; i++) begin
            if (cmd_ready === 1'b0) begin
                cmd_valid = 1'b1;
                cmd_rw = 1'($urandom);
                cmd_slave_addr = 7'($urandom);
                cmd_wdata = 8'($urandom);
            end
            @(negedge clk);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_rsp();
        int w = 0;
        while (exp_rsp.size() != 0 && w < 500) begin @(negedge clk); w++; end
        check("rsp_wait", exp_rsp.size(), 0);
        if (exp_rsp.size() != 0) begin exp_rsp.delete(); exp_acc.delete(); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        check("rst_rsp_flags", {30'd0, rsp_nack, rsp_timeout}, 32'd0);
        check("rst_cyc_stb", {30'd0, wb_bus.o_wb_cyc, wb_bus.o_wb_stb}, 32'd0);
        check("rst_we_addr", {23'd0, wb_bus.o_wb_we, wb_bus.o_wb_addr}, 32'd0);
        check("rst_wdata", wb_bus.o_wb_data, 32'd0);
        rst = 1'b0;

        issue_cmd(1'b0, 7'h50, 8'hA5, 3, 1'b1, 0, 8'h00);   wait_rsp();
        issue_cmd(1'b1, 7'h51, 8'h00, 0, 1'b1, 2, 8'h3C);   wait_rsp();
        issue_cmd(1'b1, 7'h22, 8'h00, 1, 1'b0, 0, 8'h77);   wait_rsp();
        issue_cmd(1'b0, 7'h33, 8'h12, 1000, 1'b1, 0, 8'h00); wait_rsp();
        issue_cmd(1'b0, 7'h7F, 8'hFF, 0, 1'b1, 0, 8'h00);   wait_rsp();
        issue_cmd(1'b1, 7'h01, 8'h00, 0, 1'b1, 1000, 8'h99); wait_rsp();
        issue_cmd(1'b1, 7'h10, 8'h00, T - 1, 1'b1, T - 1, 8'hC3); wait_rsp();

        for (int k = 0; k < 40; k++) begin
            issue_cmd(1'($urandom), 7'($urandom), 8'($urandom), int'($urandom_range(0, 9)),
                      ($urandom_range(0, 3) != 0), int'($urandom_range(0, 9)), 8'($urandom));
            wait_rsp();
        end

        // Reset in the middle of a busy poll: bus released next cycle, no response.
        issue_cmd(1'b1, 7'h44, 8'h00, 1000, 1'b1, 0, 8'h55);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        exp_acc.delete();
        exp_rsp.delete();
        @(posedge clk);
        #1;
        check("rstmid_cyc_stb", {30'd0, wb_bus.o_wb_cyc, wb_bus.o_wb_stb}, 32'd0);
        @(negedge clk);
        check("rstmid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rstmid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        issue_cmd(1'b1, 7'h44, 8'h00, 2, 1'b1, 1, 8'h81);   wait_rsp();
        issue_cmd(1'b0, 7'h45, 8'h6B, 0, 1'b1, 0, 8'h00);   wait_rsp();

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
